// File: rtl/square_duty_controller.sv
// Duty configuration owner for the square/pulse generator: stages host writes,
// UI steps and auto-sweep moves, and commits them only on a phase wrap.
module square_duty_controller #(
    parameter int MIN_DUTY      = 1,
    parameter int MAX_DUTY      = 99,
    parameter int STEP          = 1,
    parameter int RESET_DUTY    = 50,
    parameter int SWEEP_PERIODS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] phase,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic        cfg_cont_en,
    input  logic [1:0]  cfg_duty_mode,
    input  logic [6:0]  cfg_duty_cont,
    input  logic        step_up,
    input  logic        step_down,
    input  logic        sweep_en,
    output logic [1:0]  duty_mode,
    output logic [6:0]  duty_cont,
    output logic        cont_enable,
    output logic        pending,
    output logic        update_pulse
);

    localparam int CNT_W = (SWEEP_PERIODS > 1) ? $clog2(SWEEP_PERIODS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SWEEP_PERIODS - 1);
    localparam logic [7:0] MIN_D   = 8'(MIN_DUTY);
    localparam logic [7:0] MAX_D   = 8'(MAX_DUTY);
    localparam logic [7:0] STEP_D  = 8'(STEP);
    localparam logic [6:0] RESET_D = 7'(RESET_DUTY);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWEEP
    } state_t;

    state_t      state;
    logic [11:0] phase_prev;
    logic        wrap;
    logic [1:0]  shadow_mode;
    logic [6:0]  shadow_duty;
    logic        shadow_cont_en;
    logic [CNT_W-1:0] sweep_cnt;
    logic        sweep_down;
    logic        step_one;
    logic [6:0]  pend_duty;
    logic [6:0]  sweep_duty;
    logic        sweep_down_next;

    function automatic logic [6:0] clamp8(input logic [7:0] d);
        logic [7:0] r;
        r = d;
        if (d < MIN_D) r = MIN_D;
        if (d > MAX_D) r = MAX_D;
        return r[6:0];
    endfunction

    // Saturating step; never wraps around past either bound.
    function automatic logic [6:0] step_duty(input logic [6:0] d, input logic up);
        logic [7:0] d8;
        logic [7:0] r;
        d8 = {1'b0, d};
        if (up) r = (d8 + STEP_D > MAX_D) ? MAX_D : d8 + STEP_D;
        else    r = (d8 < MIN_D + STEP_D) ? MIN_D : d8 - STEP_D;
        return clamp8(r);
    endfunction

    assign wrap      = (phase < phase_prev);
    assign step_one  = step_up ^ step_down;
    assign cfg_ready = (state == IDLE);
    assign pending   = (state == PENDING);

    always_comb begin
        pend_duty       = step_one ? step_duty(shadow_duty, step_up) : shadow_duty;
        sweep_duty      = duty_cont;
        sweep_down_next = sweep_down;
        if (!sweep_down) begin
            if ({1'b0, duty_cont} + STEP_D >= MAX_D) begin
                sweep_duty      = MAX_D[6:0];
                sweep_down_next = 1'b1;
            end else begin
                sweep_duty = 7'({1'b0, duty_cont} + STEP_D);
            end
        end else begin
            if ({1'b0, duty_cont} <= MIN_D + STEP_D) begin
                sweep_duty      = MIN_D[6:0];
                sweep_down_next = 1'b0;
            end else begin
                sweep_duty = 7'({1'b0, duty_cont} - STEP_D);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            phase_prev     <= '0;
            duty_mode      <= 2'b00;
            duty_cont      <= RESET_D;
            cont_enable    <= 1'b0;
            shadow_mode    <= 2'b00;
            shadow_duty    <= RESET_D;
            shadow_cont_en <= 1'b0;
            sweep_cnt      <= '0;
            sweep_down     <= 1'b0;
            update_pulse   <= 1'b0;
        end else begin
            phase_prev   <= phase;
            update_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        shadow_mode    <= cfg_duty_mode;
                        shadow_duty    <= clamp8({1'b0, cfg_duty_cont});
                        shadow_cont_en <= cfg_cont_en;
                        state          <= PENDING;
                    end else if (step_one && cont_enable) begin
                        shadow_mode    <= duty_mode;
                        shadow_duty    <= step_duty(duty_cont, step_up);
                        shadow_cont_en <= cont_enable;
                        state          <= PENDING;
                    end else if (sweep_en) begin
                        sweep_cnt  <= '0;
                        sweep_down <= 1'b0;
                        state      <= SWEEP;
                    end
                end
                // A step landing on the wrap cycle is folded into the commit.
                PENDING: begin
                    shadow_duty <= pend_duty;
                    if (wrap) begin
                        duty_mode    <= shadow_mode;
                        duty_cont    <= pend_duty;
                        cont_enable  <= shadow_cont_en;
                        update_pulse <= 1'b1;
                        state        <= IDLE;
                    end
                end
                SWEEP: begin
                    if (!sweep_en) begin
                        sweep_cnt <= '0;
                        state     <= IDLE;
                    end else if (wrap) begin
                        if (sweep_cnt == CNT_LAST) begin
                            sweep_cnt      <= '0;
                            duty_cont      <= sweep_duty;
                            cont_enable    <= 1'b1;
                            sweep_down     <= sweep_down_next;
                            update_pulse   <= 1'b1;
                            shadow_mode    <= duty_mode;
                            shadow_duty    <= sweep_duty;
                            shadow_cont_en <= 1'b1;
                        end else begin
                            sweep_cnt <= sweep_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_square_duty_controller.sv
// Bench for square_duty_controller: vector table through a scoreboard queue,
// plus hand sequences for auto-sweep and reset during a staged write.
module tb_square_duty_controller;

    typedef struct {
        logic [11:0] phase;
        logic        cfg_valid;
        logic        cfg_cont_en;
        logic [1:0]  cfg_mode;
        logic [6:0]  cfg_duty;
        logic        step_up;
        logic        step_down;
        logic [1:0]  x_mode;
        logic [6:0]  x_duty;
        logic        x_cont;
        logic        x_ready;
        logic        x_pend;
        logic        x_pulse;
    } vec_t;

    typedef struct {
        logic [1:0] mode;
        logic [6:0] duty;
        logic       cont;
        logic       ready;
        logic       pend;
        logic       pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] phase;
    logic        cfg_valid, cfg_ready, cfg_cont_en;
    logic [1:0]  cfg_duty_mode;
    logic [6:0]  cfg_duty_cont;
    logic        step_up, step_down, sweep_en;
    logic [1:0]  duty_mode;
    logic [6:0]  duty_cont;
    logic        cont_enable, pending, update_pulse;

    logic        sw_sweep_en;
    logic        sw_cfg_ready, sw_cont_enable, sw_pending, sw_update_pulse;
    logic [1:0]  sw_duty_mode;
    logic [6:0]  sw_duty_cont;

    int n_compared   = 0;
    int n_mismatched = 0;
    exp_t exp_q[$];
    int   sweep_q[$];
    vec_t vecs[24];

    always #5 clk = ~clk;

    square_duty_controller dut (
        .clk(clk), .rst(rst), .phase(phase),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_cont_en(cfg_cont_en),
        .cfg_duty_mode(cfg_duty_mode), .cfg_duty_cont(cfg_duty_cont),
        .step_up(step_up), .step_down(step_down), .sweep_en(sweep_en),
        .duty_mode(duty_mode), .duty_cont(duty_cont), .cont_enable(cont_enable),
        .pending(pending), .update_pulse(update_pulse)
    );

    square_duty_controller #(.STEP(10), .SWEEP_PERIODS(2)) dut_sw (
        .clk(clk), .rst(rst), .phase(phase),
        .cfg_valid(1'b0), .cfg_ready(sw_cfg_ready), .cfg_cont_en(1'b0),
        .cfg_duty_mode(2'b00), .cfg_duty_cont(7'd0),
        .step_up(1'b0), .step_down(1'b0), .sweep_en(sw_sweep_en),
        .duty_mode(sw_duty_mode), .duty_cont(sw_duty_cont), .cont_enable(sw_cont_enable),
        .pending(sw_pending), .update_pulse(sw_update_pulse)
    );

    function automatic vec_t mk(input int ph, input bit cv, input bit ce, input int cm, input int cd,
                                input bit su, input bit sd, input int xm, input int xd,
                                input bit xc, input bit xr, input bit xp, input bit xu);
        vec_t v;
        v.phase = 12'(ph); v.cfg_valid = cv; v.cfg_cont_en = ce;
        v.cfg_mode = 2'(cm); v.cfg_duty = 7'(cd); v.step_up = su; v.step_down = sd;
        v.x_mode = 2'(xm); v.x_duty = 7'(xd); v.x_cont = xc;
        v.x_ready = xr; v.x_pend = xp; v.x_pulse = xu;
        return v;
    endfunction

    task automatic checkVal(input string name, input int act, input int req);
        n_compared++;
        if (act != req) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clk);
        phase = v.phase; cfg_valid = v.cfg_valid; cfg_cont_en = v.cfg_cont_en;
        cfg_duty_mode = v.cfg_mode; cfg_duty_cont = v.cfg_duty;
        step_up = v.step_up; step_down = v.step_down;
        e.mode = v.x_mode; e.duty = v.x_duty; e.cont = v.x_cont;
        e.ready = v.x_ready; e.pend = v.x_pend; e.pulse = v.x_pulse;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkVal({tag, " scoreboard empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            checkVal({tag, " duty_mode"},    duty_mode,    e.mode);
            checkVal({tag, " duty_cont"},    duty_cont,    e.duty);
            checkVal({tag, " cont_enable"},  cont_enable,  e.cont);
            checkVal({tag, " cfg_ready"},    cfg_ready,    e.ready);
            checkVal({tag, " pending"},      pending,      e.pend);
            checkVal({tag, " update_pulse"}, update_pulse, e.pulse);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, " duty_mode"},    duty_mode,    0);
        checkVal({tag, " duty_cont"},    duty_cont,    50);
        checkVal({tag, " cont_enable"},  cont_enable,  0);
        checkVal({tag, " cfg_ready"},    cfg_ready,    1);
        checkVal({tag, " pending"},      pending,      0);
        checkVal({tag, " update_pulse"}, update_pulse, 0);
    endtask

    initial begin
        //          phase cv ce cm cd  su sd | mode duty cont rdy pend pulse
        vecs[0]  = mk(1000, 1, 1, 0, 30,  0, 0,  0, 50, 0, 0, 1, 0);
        vecs[1]  = mk(4095, 0, 0, 0, 0,   0, 0,  0, 50, 0, 0, 1, 0);
        vecs[2]  = mk(5,    0, 0, 0, 0,   0, 0,  0, 30, 1, 1, 0, 1);
        vecs[3]  = mk(100,  0, 0, 0, 0,   0, 0,  0, 30, 1, 1, 0, 0);
        vecs[4]  = mk(50,   1, 1, 3, 0,   0, 0,  0, 30, 1, 0, 1, 0);
        vecs[5]  = mk(60,   0, 0, 0, 0,   0, 0,  0, 30, 1, 0, 1, 0);
        vecs[6]  = mk(10,   0, 0, 0, 0,   0, 0,  3, 1,  1, 1, 0, 1);
        vecs[7]  = mk(20,   0, 0, 0, 0,   1, 1,  3, 1,  1, 1, 0, 0);
        vecs[8]  = mk(30,   1, 0, 2, 98,  0, 0,  3, 1,  1, 0, 1, 0);
        vecs[9]  = mk(5,    0, 0, 0, 0,   0, 0,  2, 98, 0, 1, 0, 1);
        vecs[10] = mk(15,   0, 0, 0, 0,   1, 0,  2, 98, 0, 1, 0, 0);
        vecs[11] = mk(25,   0, 0, 0, 0,   0, 1,  2, 98, 0, 1, 0, 0);
        vecs[12] = mk(35,   1, 1, 0, 98,  0, 0,  2, 98, 0, 0, 1, 0);
        vecs[13] = mk(0,    0, 0, 0, 0,   0, 0,  0, 98, 1, 1, 0, 1);
        vecs[14] = mk(10,   0, 0, 0, 0,   1, 0,  0, 98, 1, 0, 1, 0);
        vecs[15] = mk(20,   0, 0, 0, 0,   1, 0,  0, 98, 1, 0, 1, 0);
        vecs[16] = mk(30,   0, 0, 0, 0,   0, 0,  0, 98, 1, 0, 1, 0);
        vecs[17] = mk(1,    0, 0, 0, 0,   0, 0,  0, 99, 1, 1, 0, 1);
        vecs[18] = mk(5,    0, 0, 0, 0,   0, 1,  0, 99, 1, 0, 1, 0);
        vecs[19] = mk(6,    0, 0, 0, 0,   0, 1,  0, 99, 1, 0, 1, 0);
        vecs[20] = mk(7,    0, 0, 0, 0,   1, 0,  0, 99, 1, 0, 1, 0);
        vecs[21] = mk(2,    0, 0, 0, 0,   0, 0,  0, 98, 1, 1, 0, 1);
        vecs[22] = mk(3,    1, 1, 1, 120, 1, 0,  0, 98, 1, 0, 1, 0);
        vecs[23] = mk(0,    0, 0, 0, 0,   0, 0,  1, 99, 1, 1, 0, 1);

        rst = 1'b1; phase = '0; cfg_valid = 1'b0; cfg_cont_en = 1'b0;
        cfg_duty_mode = '0; cfg_duty_cont = '0; step_up = 1'b0; step_down = 1'b0;
        sweep_en = 1'b0; sw_sweep_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("reset");

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i));
        end

        // Auto-sweep on the STEP=10 / SWEEP_PERIODS=2 instance.
        sweep_q = '{60, 70, 80, 90, 99, 89, 79};
        @(negedge clk);
        cfg_valid = 1'b0; step_up = 1'b0; step_down = 1'b0;
        sw_sweep_en = 1'b1;
        @(posedge clk);
        for (int w = 0; w < 14; w++) begin
            @(negedge clk); phase = 12'd2000;
            @(posedge clk);
            @(negedge clk); phase = 12'd0;
            @(posedge clk);
            #1;
            checkVal($sformatf("sweep wrap%0d update_pulse", w), sw_update_pulse, (w % 2 == 1) ? 1 : 0);
            if (w == 0) begin
                checkVal("sweep first wrap cont_enable", sw_cont_enable, 0);
                checkVal("sweep cfg_ready", sw_cfg_ready, 0);
            end
            if (sw_update_pulse) begin
                if (sweep_q.size() == 0) begin
                    checkVal("sweep extra step", 0, 1);
                end else begin
                    checkVal($sformatf("sweep wrap%0d duty_cont", w), sw_duty_cont, sweep_q.pop_front());
                    checkVal($sformatf("sweep wrap%0d cont_enable", w), sw_cont_enable, 1);
                end
            end
        end
        @(negedge clk);
        sw_sweep_en = 1'b0;
        @(posedge clk);
        #1;
        checkVal("sweep exit cfg_ready", sw_cfg_ready, 1);
        checkVal("sweep exit duty_cont", sw_duty_cont, 79);
        checkVal("sweep steps left", sweep_q.size(), 0);

        // Reset while a write is staged must discard it entirely.
        @(negedge clk);
        phase = 12'd200; cfg_valid = 1'b1; cfg_cont_en = 1'b1;
        cfg_duty_mode = 2'b10; cfg_duty_cont = 7'd20;
        @(posedge clk);
        #1;
        checkVal("staged pending", pending, 1);
        checkVal("staged cfg_ready", cfg_ready, 0);
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkResetOutputs("async reset");
        checkVal("async reset sweep duty", sw_duty_cont, 50);
        @(negedge clk);
        rst = 1'b0; phase = 12'd100;
        @(negedge clk);
        phase = 12'd4;
        @(posedge clk);
        #1;
        checkResetOutputs("post-reset wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/square_duty_controller.md
Name: square_duty_controller

Overview:
- Owns the duty configuration (duty_mode, duty_cont, cont_enable) driving the square/pulse generator.
- Accepts host config writes, step up/down pulses from the UI debouncer, and an auto-sweep mode.
- Commits every change only at a phase wrap, so the generator never emits a truncated or split pulse.
- Sits between the control/UI logic and the square generator; it observes the same 12-bit phase accumulator output.

Parameters:
- MIN_DUTY, 1, lowest legal continuous duty (percent).
- MAX_DUTY, 99, highest legal continuous duty (percent).
- STEP, 1, duty increment per step_up/step_down or per sweep step.
- RESET_DUTY, 50, continuous duty value after reset.
- SWEEP_PERIODS, 16, phase wraps between sweep steps (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- phase  in  12  generator phase accumulator value
- cfg_valid  in  1  host config write request
- cfg_ready  out  1  controller can accept config
- cfg_cont_en  in  1  requested continuous-duty enable
- cfg_duty_mode  in  2  requested fixed duty: 00=1/2, 01=1/3, 10=1/4, 11=1/7
- cfg_duty_cont  in  7  requested continuous duty (percent)
- step_up  in  1  one-cycle pulse: raise duty by STEP
- step_down  in  1  one-cycle pulse: lower duty by STEP
- sweep_en  in  1  level: enable auto-sweep
- duty_mode  out  2  active fixed duty to generator
- duty_cont  out  7  active continuous duty to generator
- cont_enable  out  1  active continuous-mode enable to generator
- pending  out  1  staged config awaiting a wrap
- update_pulse  out  1  one-cycle strobe when active config changes

Behaviour:
- Wrap detect: phase_prev is registered every cycle (reset 0). wrap = (phase < phase_prev), evaluated combinationally in the current cycle.
- Registers: active set (the outputs) and shadow set (staged values).
- Reset: active and shadow = {mode 00, duty RESET_DUTY, cont_en 0}. State IDLE, pending 0, update_pulse 0, sweep counter 0, sweep dir up. cfg_ready is 1 once reset is released.
- Clamp rule: every duty written to shadow is clamped to [MIN_DUTY, MAX_DUTY]. Step arithmetic uses 8-bit unsigned with saturation at the bounds, with no wrap-around.
- IDLE:
  - cfg_ready=1.
  - cfg_valid: shadow <= clamped cfg fields; go PENDING.
  - Otherwise, step_up xor step_down while active cont_enable=1: shadow <= active with duty ±STEP; go PENDING.
  - Steps are ignored when cont_enable=0, and when both step inputs are high.
  - Otherwise, sweep_en=1: go SWEEP with counter 0 and dir up.
  - Priority: cfg_valid > step > sweep_en.
  - A wrap in the same cycle as capture does not commit; the commit waits for the next wrap.
- PENDING:
  - cfg_ready=0, pending=1.
  - A step pulse updates shadow duty ±STEP, saturating. Steps accumulate.
  - On wrap: active <= shadow, update_pulse=1 in the following cycle, go IDLE.
  - Mid-PENDING sweep_en is deferred until the return to IDLE.
- SWEEP:
  - cfg_ready=0. Steps and cfg are ignored.
  - On each wrap the counter increments.
  - When counter == SWEEP_PERIODS-1: counter <= 0, cont_enable <= 1, update_pulse. Duty moves by STEP in dir.
  - Up: if duty+STEP >= MAX_DUTY then duty=MAX_DUTY and dir=down.
  - Down: if duty <= MIN_DUTY+STEP then duty=MIN_DUTY and dir=up.
  - Shadow tracks active.
  - sweep_en=0: go IDLE the next cycle. Active values are retained and the counter clears.
- Latency:
  - Outputs change exactly one clock after the wrap cycle; update_pulse is coincident with that change.
  - cfg_ready drops the cycle after the accepting handshake.
- Reset mid-operation: async rst discards shadow and pending changes immediately, and all outputs return to their reset values.

Test Plan:
- Reset release -> duty_mode=00, duty_cont=50, cont_enable=0, cfg_ready=1, pending=0, update_pulse=0.
- cfg write {cont_en=1, duty=30} while phase ramps 1000→4095→5 -> pending=1 until the wrap, duty_cont=30 one clock after phase reads 5, single update_pulse, cfg_ready back to 1.
- cont_enable=1, duty=98: two step_up pulses before a wrap -> committed duty=99 (saturated). duty=0 on cfg -> clamped to 1.
- step_up and step_down high in the same cycle, and step_up with cont_enable=0 -> no state change, pending stays 0.
- SWEEP_PERIODS=2, STEP=10, start duty=50, sweep_en=1 -> duty sequence 60,70,80,90,99,89,... every 2 wraps; cont_enable=1 after the first step.
- cfg accepted (pending=1), then rst pulsed before the wrap -> outputs at reset values, no update_pulse at the following wrap.
